// File: rtl/systolic_result_drain_pkg.sv
// Shared types and sizing helpers for the systolic result drain path.
// Imported by the drain FSM and the beat mux.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } drain_state_e;

    function automatic int unsigned beats_per_row(input int unsigned cols,
                                                  input int unsigned lanes);
        return cols / lanes;
    endfunction

    // Index fields never collapse to zero width, even for a single row or beat.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_ROWS     = 64;
    localparam int unsigned DEF_COLS     = 64;
    localparam int unsigned DEF_OP_WIDTH = 48;
    localparam int unsigned DEF_LANES    = 8;
    localparam int unsigned DEF_ROW_W    = idx_width(DEF_ROWS);
    localparam int unsigned DEF_BEAT_W   = idx_width(beats_per_row(DEF_COLS, DEF_LANES));

endpackage

// File: rtl/systolic_result_drain_beat_mux.sv
// Combinational select of one LANES-wide beat (row, beat) out of the flat result matrix.
// Isolated from the FSM so a pipeline stage can be added here later.
module systolic_beat_mux
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS     = 64,
    parameter int unsigned COLS     = 64,
    parameter int unsigned OP_WIDTH = 48,
    parameter int unsigned LANES    = 8,
    parameter int unsigned ROW_W    = idx_width(ROWS),
    parameter int unsigned BEAT_W   = idx_width(beats_per_row(COLS, LANES))
) (
    input  logic [ROWS*COLS*OP_WIDTH-1:0] matrix,
    input  logic [ROW_W-1:0]              row,
    input  logic [BEAT_W-1:0]             beat,
    output logic [LANES*OP_WIDTH-1:0]     beat_data
);

    localparam int unsigned MAT_BITS  = ROWS * COLS * OP_WIDTH;
    localparam int unsigned BIT_W     = idx_width(MAT_BITS);
    localparam int unsigned ROW_BITS  = COLS * OP_WIDTH;
    localparam int unsigned BEAT_BITS = LANES * OP_WIDTH;

    logic [BIT_W-1:0] base;

    always_comb begin
        base      = BIT_W'(row) * BIT_W'(ROW_BITS) + BIT_W'(beat) * BIT_W'(BEAT_BITS);
        beat_data = matrix[base +: BEAT_BITS];
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Drains the systolic array's output matrix row-major as valid/ready beats of LANES
// accumulators, holding drain_busy until the final beat is accepted.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS     = 64,
    parameter int unsigned COLS     = 64,
    parameter int unsigned OP_WIDTH = 48,
    parameter int unsigned LANES    = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    compute_done,
    input  logic [31:0]                             cycles_count,
    input  logic [ROWS*COLS*OP_WIDTH-1:0]           output_matrix,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [LANES*OP_WIDTH-1:0]               out_data,
    output logic [idx_width(ROWS)-1:0]              out_row,
    output logic [idx_width(COLS/LANES)-1:0]        out_beat,
    output logic                                    out_row_last,
    output logic                                    out_last,
    output logic                                    drain_busy,
    output logic                                    drain_done,
    output logic [31:0]                             perf_cycles,
    output logic                                    overrun_err
);

    localparam int unsigned BPR       = beats_per_row(COLS, LANES);
    localparam int unsigned ROW_W     = idx_width(ROWS);
    localparam int unsigned BEAT_W    = idx_width(BPR);
    localparam int unsigned BEAT_BITS = LANES * OP_WIDTH;

    if (COLS % LANES != 0) begin : g_lanes_chk
        $error("systolic_result_drain: LANES must divide COLS");
    end

    drain_state_e          state_q, state_d;
    logic                  done_q;
    logic                  out_valid_q, out_valid_d;
    logic [BEAT_BITS-1:0]  out_data_q, out_data_d;
    logic [ROW_W-1:0]      out_row_q, out_row_d;
    logic [BEAT_W-1:0]     out_beat_q, out_beat_d;
    logic                  out_row_last_q, out_row_last_d;
    logic                  out_last_q, out_last_d;
    logic                  drain_busy_q, drain_busy_d;
    logic                  drain_done_q, drain_done_d;
    logic [31:0]           perf_cycles_q, perf_cycles_d;
    logic                  overrun_err_q, overrun_err_d;

    logic                  start_edge;
    logic [ROW_W-1:0]      sel_row;
    logic [BEAT_W-1:0]     sel_beat;
    logic                  sel_row_last;
    logic                  sel_last;
    logic [BEAT_BITS-1:0]  mux_data;

    // Index of the beat to load: current position in LOAD, the successor in STREAM.
    always_comb begin
        sel_row  = out_row_q;
        sel_beat = out_beat_q;
        if (state_q == STREAM) begin
            if (out_row_last_q) begin
                sel_beat = '0;
                sel_row  = out_row_q + ROW_W'(1);
            end else begin
                sel_beat = out_beat_q + BEAT_W'(1);
            end
        end
        sel_row_last = (sel_beat == BEAT_W'(BPR - 1));
        sel_last     = sel_row_last && (sel_row == ROW_W'(ROWS - 1));
    end

    systolic_beat_mux #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .OP_WIDTH (OP_WIDTH),
        .LANES    (LANES),
        .ROW_W    (ROW_W),
        .BEAT_W   (BEAT_W)
    ) u_beat_mux (
        .matrix    (output_matrix),
        .row       (sel_row),
        .beat      (sel_beat),
        .beat_data (mux_data)
    );

    always_comb begin
        state_d        = state_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_row_d      = out_row_q;
        out_beat_d     = out_beat_q;
        out_row_last_d = out_row_last_q;
        out_last_d     = out_last_q;
        drain_busy_d   = drain_busy_q;
        drain_done_d   = 1'b0;
        perf_cycles_d  = perf_cycles_q;
        overrun_err_d  = overrun_err_q;
        start_edge     = compute_done & ~done_q;

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    out_row_d     = '0;
                    out_beat_d    = '0;
                    perf_cycles_d = cycles_count;
                    drain_busy_d  = 1'b1;
                    state_d       = LOAD;
                end
            end
            LOAD: begin
                out_data_d     = mux_data;
                out_row_d      = sel_row;
                out_beat_d     = sel_beat;
                out_row_last_d = sel_row_last;
                out_last_d     = sel_last;
                out_valid_d    = 1'b1;
                state_d        = STREAM;
            end
            STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        out_valid_d  = 1'b0;
                        drain_busy_d = 1'b0;
                        drain_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        out_data_d     = mux_data;
                        out_row_d      = sel_row;
                        out_beat_d     = sel_beat;
                        out_row_last_d = sel_row_last;
                        out_last_d     = sel_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A start edge coinciding with final acceptance still counts: IDLE is not yet re-entered.
        if (start_edge && state_q != IDLE) begin
            overrun_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            done_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_row_q      <= '0;
            out_beat_q     <= '0;
            out_row_last_q <= 1'b0;
            out_last_q     <= 1'b0;
            drain_busy_q   <= 1'b0;
            drain_done_q   <= 1'b0;
            perf_cycles_q  <= '0;
            overrun_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            done_q         <= compute_done;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_row_q      <= out_row_d;
            out_beat_q     <= out_beat_d;
            out_row_last_q <= out_row_last_d;
            out_last_q     <= out_last_d;
            drain_busy_q   <= drain_busy_d;
            drain_done_q   <= drain_done_d;
            perf_cycles_q  <= perf_cycles_d;
            overrun_err_q  <= overrun_err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_row      = out_row_q;
    assign out_beat     = out_beat_q;
    assign out_row_last = out_row_last_q;
    assign out_last     = out_last_q;
    assign drain_busy   = drain_busy_q;
    assign drain_done   = drain_done_q;
    assign perf_cycles  = perf_cycles_q;
    assign overrun_err  = overrun_err_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain on a 4x4 matrix, 2 lanes, 8-bit elements.
module tb_systolic_result_drain;

    localparam int unsigned ROWS     = 4;
    localparam int unsigned COLS     = 4;
    localparam int unsigned OP_WIDTH = 8;
    localparam int unsigned LANES    = 2;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          compute_done;
    logic [31:0]                   cycles_count;
    logic [ROWS*COLS*OP_WIDTH-1:0] output_matrix;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*OP_WIDTH-1:0]     out_data;
    logic [1:0]                    out_row;
    logic [0:0]                    out_beat;
    logic                          out_row_last;
    logic                          out_last;
    logic                          drain_busy;
    logic                          drain_done;
    logic [31:0]                   perf_cycles;
    logic                          overrun_err;

    systolic_result_drain #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .OP_WIDTH (OP_WIDTH),
        .LANES    (LANES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .compute_done  (compute_done),
        .cycles_count  (cycles_count),
        .output_matrix (output_matrix),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_row       (out_row),
        .out_beat      (out_beat),
        .out_row_last  (out_row_last),
        .out_last      (out_last),
        .drain_busy    (drain_busy),
        .drain_done    (drain_done),
        .perf_cycles   (perf_cycles),
        .overrun_err   (overrun_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Element (r,c) = r*16+c; beat = {elem(c+1), elem(c)}.
    logic [15:0] exp_data [8] = '{16'h0100, 16'h0302, 16'h1110, 16'h1312,
                                  16'h2120, 16'h2322, 16'h3130, 16'h3332};

    logic [15:0] acc_data [16];
    logic [4:0]  acc_meta [16];
    logic [15:0] stall_seen [8];
    int          n_beats, n_stall, busy_cycles, done_cycle, first_valid, done_pulses;
    logic [31:0] perf_mid;

    // Drives out_ready/compute_done/rst around a drain and records what it observes.
    task automatic run_drain(input int stall_beat, input int stall_len, input int toggle_beat,
                             input int rst_beat, input int limit);
        int toggled;
        toggled     = 0;
        n_beats     = 0;
        n_stall     = 0;
        busy_cycles = 0;
        done_cycle  = -1;
        first_valid = -1;
        done_pulses = 0;
        perf_mid    = '0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            cycles_count = cycles_count + 32'h11;
            if (c == 4) perf_mid = perf_cycles;
            if (drain_busy) busy_cycles++;
            if (drain_done) begin
                done_pulses++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (out_valid && first_valid < 0) first_valid = c;
            if (rst_beat >= 0 && out_valid && n_beats == rst_beat) begin
                rst = 1'b0;
                break;
            end
            if (toggled == 1) begin
                compute_done = 1'b1;
                toggled = 2;
            end else if (out_valid && n_beats == toggle_beat && toggled == 0) begin
                compute_done = 1'b0;
                toggled = 1;
            end
            if (out_valid && n_beats == stall_beat && n_stall < stall_len) begin
                out_ready = 1'b0;
                stall_seen[n_stall] = out_data;
                n_stall++;
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    if (n_beats < 16) begin
                        acc_data[n_beats] = out_data;
                        acc_meta[n_beats] = {out_row, out_beat, out_row_last, out_last};
                    end
                    n_beats++;
                end
            end
            if (done_cycle >= 0) break;
        end
    endtask

    task automatic start_drain(input logic [31:0] cc);
        @(negedge clk);
        compute_done = 1'b0;
        @(negedge clk);
        compute_done = 1'b1;
        cycles_count = cc;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        compute_done = 1'b0;
        out_ready = 1'b1;
        cycles_count = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, drain_busy, drain_done, overrun_err, out_last, out_row_last} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {out_valid, drain_busy, drain_done, overrun_err, out_last, out_row_last});
        end
        n_cmp++;
        if ({out_data, perf_cycles, out_row, out_beat} !== 51'b0) begin
            n_err++;
            $display("FAIL reset_regs: got data=%h perf=%h row=%0d beat=%0d expected all zero",
                     out_data, perf_cycles, out_row, out_beat);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic;
        logic [4:0] em;
        start_drain(32'h1234);
        run_drain(-1, 0, -1, -1, 40);
        n_cmp++;
        if (first_valid !== 1) begin
            n_err++; $display("FAIL basic_latency: got %0d expected 1", first_valid);
        end
        n_cmp++;
        if (n_beats !== 8) begin
            n_err++; $display("FAIL basic_beats: got %0d expected 8", n_beats);
        end
        for (int i = 0; i < 8; i++) begin
            em = {i[2:1], i[0], i[0], (i == 7)};
            n_cmp++;
            if (acc_data[i] !== exp_data[i] || acc_meta[i] !== em) begin
                n_err++;
                $display("FAIL basic_beat%0d: got data=%h meta=%b expected data=%h meta=%b",
                         i, acc_data[i], acc_meta[i], exp_data[i], em);
            end
        end
        n_cmp++;
        if (done_cycle !== 9 || busy_cycles !== 9) begin
            n_err++;
            $display("FAIL basic_timing: got done=%0d busy=%0d expected done=9 busy=9",
                     done_cycle, busy_cycles);
        end
        @(negedge clk);
        n_cmp++;
        if ({drain_done, out_valid, drain_busy} !== 3'b000) begin
            n_err++;
            $display("FAIL basic_after: got done/valid/busy=%b expected 000",
                     {drain_done, out_valid, drain_busy});
        end
        n_cmp++;
        if (perf_mid !== 32'h1234 || perf_cycles !== 32'h1234) begin
            n_err++;
            $display("FAIL perf_snapshot: got mid=%h end=%h expected 00001234", perf_mid, perf_cycles);
        end
        n_cmp++;
        if (overrun_err !== 1'b0) begin
            n_err++; $display("FAIL basic_overrun: got %b expected 0", overrun_err);
        end
    endtask

    task automatic test_backpressure;
        start_drain(32'h0);
        run_drain(3, 3, -1, -1, 40);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (stall_seen[i] !== 16'h1312) begin
                n_err++; $display("FAIL bp_stable%0d: got %h expected 1312", i, stall_seen[i]);
            end
        end
        n_cmp++;
        if (n_beats !== 8) begin
            n_err++; $display("FAIL bp_beats: got %0d expected 8", n_beats);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (acc_data[i] !== exp_data[i]) begin
                n_err++; $display("FAIL bp_beat%0d: got %h expected %h", i, acc_data[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (done_cycle !== 12 || busy_cycles !== 12) begin
            n_err++;
            $display("FAIL bp_timing: got done=%0d busy=%0d expected done=12 busy=12",
                     done_cycle, busy_cycles);
        end
    endtask

    task automatic test_overrun;
        start_drain(32'h0);
        run_drain(-1, 0, 4, -1, 40);
        n_cmp++;
        if (overrun_err !== 1'b1) begin
            n_err++; $display("FAIL ovr_set: got %b expected 1", overrun_err);
        end
        n_cmp++;
        if (n_beats !== 8 || done_cycle !== 9 || acc_data[7] !== 16'h3332) begin
            n_err++;
            $display("FAIL ovr_stream: got beats=%0d done=%0d last=%h expected 8/9/3332",
                     n_beats, done_cycle, acc_data[7]);
        end
        start_drain(32'h0);
        run_drain(-1, 0, -1, -1, 40);
        n_cmp++;
        if (n_beats !== 8 || done_cycle !== 9 || acc_data[0] !== 16'h0100) begin
            n_err++;
            $display("FAIL ovr_second: got beats=%0d done=%0d first=%h expected 8/9/0100",
                     n_beats, done_cycle, acc_data[0]);
        end
        n_cmp++;
        if (overrun_err !== 1'b1) begin
            n_err++; $display("FAIL ovr_sticky: got %b expected 1", overrun_err);
        end
    endtask

    task automatic test_reset_mid_drain;
        int pulses;
        pulses = 0;
        start_drain(32'h0);
        run_drain(-1, 0, -1, 5, 40);
        #1;
        n_cmp++;
        if (n_beats !== 5 || {out_valid, drain_busy, overrun_err} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mid: got beats=%0d valid/busy/ovr=%b expected 5 000",
                     n_beats, {out_valid, drain_busy, overrun_err});
        end
        compute_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (drain_done) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++; $display("FAIL rst_no_done: got %0d pulses expected 0", pulses);
        end
        rst = 1'b1;
        start_drain(32'h0);
        run_drain(-1, 0, -1, -1, 40);
        n_cmp++;
        if (n_beats !== 8 || done_cycle !== 9 || acc_data[7] !== 16'h3332) begin
            n_err++;
            $display("FAIL rst_redrain: got beats=%0d done=%0d last=%h expected 8/9/3332",
                     n_beats, done_cycle, acc_data[7]);
        end
    endtask

    task automatic test_level_held;
        int extra;
        extra = 0;
        start_drain(32'h55);
        run_drain(-1, 0, -1, -1, 40);
        n_cmp++;
        if (n_beats !== 8 || done_cycle !== 9) begin
            n_err++;
            $display("FAIL lvl_drain: got beats=%0d done=%0d expected 8/9", n_beats, done_cycle);
        end
        repeat (24) begin
            @(negedge clk);
            if (out_valid || drain_busy || drain_done) extra++;
        end
        n_cmp++;
        if (extra !== 0 || overrun_err !== 1'b0) begin
            n_err++;
            $display("FAIL lvl_single: got active=%0d ovr=%b expected 0 0", extra, overrun_err);
        end
    endtask

    initial begin
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                output_matrix[(r*4+c)*8 +: 8] = 8'(r*16 + c);
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_reset_mid_drain();
        test_level_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Reader end of the systolic array's result interface.
- Watches the array's compute_done and reads the flat output_matrix it holds.
- Streams the matrix out row-major as valid/ready beats of LANES accumulators toward the writeback/DMA path.
- Asserts drain_busy so the controller keeps the array's en low until every result has been accepted.

Parameters:
- ROWS, 64, array rows.
- COLS, 64, array columns.
- OP_WIDTH, 48, accumulator width per element.
- LANES, 8, elements per output beat; must divide COLS (elaboration-time assertion).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- compute_done  in  1  level from array; a rising edge starts a drain.
- cycles_count  in  32  array cycle counter, snapshotted at drain start.
- output_matrix  in  ROWS*COLS*OP_WIDTH  flat results; element (r,c) at bits [(r*COLS+c)*OP_WIDTH +: OP_WIDTH].
- out_valid  out  1  beat available.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  LANES*OP_WIDTH  lane k = element (row, beat*LANES+k) at bits [k*OP_WIDTH +: OP_WIDTH].
- out_row  out  $clog2(ROWS)  row index of the current beat.
- out_beat  out  $clog2(COLS/LANES)  beat index within the row; width is 1 if COLS==LANES.
- out_row_last  out  1  last beat of the row.
- out_last  out  1  last beat of the matrix.
- drain_busy  out  1  high from the start edge through final acceptance.
- drain_done  out  1  one-cycle pulse after final acceptance.
- perf_cycles  out  32  cycles_count captured at start.
- overrun_err  out  1  sticky; set by a start edge while busy.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; done_q (compute_done delay flop) 0; counters 0.
- Start edge: compute_done & ~done_q.
- FSM IDLE:
  - On start edge: row=0, beat=0, perf_cycles<=cycles_count, drain_busy<=1, go to LOAD.
- FSM LOAD (exactly 1 cycle):
  - Register the mux of beat (row,beat) from output_matrix into out_data.
  - Set out_valid=1, go to STREAM.
  - Start edge to first out_valid is 2 cycles.
- FSM STREAM:
  - While out_valid & ~out_ready: out_data, out_row, out_beat, out_row_last, out_last held stable.
  - On handshake of a non-last beat: advance beat; on wrap, beat=0 and row+1.
  - Load the next beat in the same edge, so full throughput is 1 beat/cycle with out_ready high.
  - On handshake with out_last=1: out_valid<=0, drain_busy<=0, drain_done<=1 for one cycle, go to IDLE.
- Flags:
  - out_row_last = (beat == COLS/LANES-1).
  - out_last = out_row_last & (row == ROWS-1).
  - Both are registered with out_data.
- Total beats = ROWS*COLS/LANES. Minimum drain time = beats + 1 cycles from start edge to drain_done.
- Start edge in LOAD/STREAM: ignored for data; overrun_err<=1, which is sticky until reset.
- Start edge in the same cycle as final acceptance: treated as overrun (IDLE must be re-entered first); the controller must not do this.
- compute_done falling during a drain: no effect.
- output_matrix is sampled live at each beat load, not snapshotted. The controller must hold array en low while drain_busy=1 so the array outputs stay stable.
- Reset asserted mid-drain: immediate return to IDLE, out_valid=0, no drain_done pulse.
- No arithmetic on data; bits pass through unmodified, signed interpretation is downstream.

Decomposition:
- Package systolic_pkg:
  - Drain FSM state enum (IDLE, LOAD, STREAM).
  - Helper function beats_per_row(COLS, LANES).
  - Localparam idx widths.
- One sub-module, systolic_beat_mux: combinational select of the LANES*OP_WIDTH slice for (row,beat) from output_matrix. Kept separate so the wide mux can be pipelined later without touching the FSM.

Test Plan:
- Basic drain, ROWS=4, COLS=4, LANES=2, element (r,c)=r*16+c, out_ready=1:
  - Pulse compute_done high and hold it.
  - Expect the first beat 2 cycles later: data {1,0}, row 0, beat 0.
  - Expect 8 consecutive beats; beat 7 = {0x33,0x32} with out_last=1.
  - Expect drain_done the cycle after beat 7; drain_busy high for 9 cycles.
- Backpressure:
  - Drop out_ready for 3 cycles on beat 3 (row 1, beat 1).
  - out_data={0x13,0x12} stays stable; no beat lost or duplicated; drain_done delayed 3 cycles.
- perf snapshot:
  - cycles_count=0x1234 at the start edge, then changing during the drain.
  - perf_cycles=0x1234 throughout and after the drain.
- Overrun:
  - Toggle compute_done low then high during beat 4.
  - Expect overrun_err=1 and sticky; stream completes normally with 8 beats.
  - A second start edge after drain_done starts a fresh drain while overrun_err stays 1.
- Reset mid-drain:
  - Assert rst low during beat 5.
  - Expect out_valid, drain_busy, overrun_err =0 immediately (async); no drain_done.
  - After release plus a new start edge, a full 8-beat drain occurs.
- Level-held compute_done:
  - Hold compute_done high across two drains' worth of cycles.
  - Expect exactly one drain and no overrun_err.
